// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the five-stage mycpu_core pipe
// Stage bit order on stall/flush: 0=PC 1=IF 2=ID 3=EX 4=MEM 5=WB.
// Ports:
//   clk, rst (async, active-low)          clock and reset
//   stallreq[NREQ]                        level stall requests, source i holds stages 0..REQ_STAGE[i]
//   mc_start, mc_done                     multi-cycle EX op launch / completion handshake
//   flush_req, flush_pc                   flush pulse and its redirect target
//   stall, flush                          per-stage hold / bubble controls
//   redirect_valid, redirect_pc           IF redirect during the flush cycle
//   mc_abort                              kill the in-flight multi-cycle op
//   stall_timeout                         sticky watchdog flag
//   perf_stall_cyc, perf_flush_cnt        performance counters, built only with PIPE_CTRL_PERF_CNT_EN
module pipe_hazard_ctrl #(
   parameter int                STAGES    = 6,
   parameter int                NREQ      = 2,
   parameter logic [4*NREQ-1:0] REQ_STAGE = {4'd3, 4'd2},
   parameter int                MC_STAGE  = 3,
   parameter int                TIMEOUT   = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stallreq,
   input  logic              mc_start,
   input  logic              mc_done,
   input  logic              flush_req,
   input  logic [31:0]       flush_pc,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              mc_abort,
   output logic              stall_timeout,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_flush_cnt
);
   typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;
   // Holding WB would deadlock the pipe, so the deepest holdable stage is STAGES-2.
   function automatic int clamp(input int s);
      return (s >= STAGES - 1) ? STAGES - 2 : s;
   endfunction
   localparam int                CW         = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]     WD_MAX     = CW'(TIMEOUT);
   localparam int                MC_DEPTH   = clamp(MC_STAGE);
   localparam logic [STAGES-1:0] FLUSH_MASK = {1'b0, {(STAGES-2){1'b1}}, 1'b0};
   state_t            state;
   logic              abort_q;
   logic              mc_busy;
   logic              in_flush;
   logic [STAGES-1:0] req_stall;
   logic [STAGES-1:0] bubble;
   logic [CW-1:0]     wd_cnt;
   // FLUSH ignores mc_start/mc_done, so mc_busy is only live in RUN and MC_WAIT.
   assign mc_busy  = ((state == RUN && mc_start) || state == MC_WAIT) && !mc_done;
   assign in_flush = state == FLUSH;
   always_comb begin
      req_stall = '0;
      for (int k = 0; k < STAGES; k++) begin
         for (int i = 0; i < NREQ; i++)
            if (stallreq[i] && k <= clamp(int'(REQ_STAGE[4*i +: 4]))) req_stall[k] = 1'b1;
         if (mc_busy && k <= MC_DEPTH) req_stall[k] = 1'b1;
      end
   end
   // Stalls always form a prefix 0..D, so the bubble sits where the prefix ends.
   always_comb begin
      bubble = '0;
      for (int k = 1; k < STAGES; k++)
         bubble[k] = req_stall[k-1] & ~req_stall[k];
   end
   // Combinational outputs are forced quiet while reset is asserted.
   assign stall          = (rst && !in_flush) ? req_stall : '0;
   assign flush          = !rst ? '0 : in_flush ? FLUSH_MASK : bubble;
   assign redirect_valid = rst && in_flush;
   assign mc_abort       = rst && in_flush && abort_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         redirect_pc <= '0;
         abort_q     <= 1'b0;
      end else if (flush_req) begin
         state       <= FLUSH;
         redirect_pc <= flush_pc;
         abort_q     <= state == MC_WAIT;
      end else begin
         state       <= mc_busy ? MC_WAIT : RUN;
         abort_q     <= 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt        <= '0;
         stall_timeout <= 1'b0;
      end else if (stall[0]) begin
         wd_cnt <= (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + CW'(1);
         if (wd_cnt >= WD_MAX - CW'(1)) stall_timeout <= 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end
`ifdef PIPE_CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cyc <= '0;
         perf_flush_cnt <= '0;
      end else begin
         perf_stall_cyc <= perf_stall_cyc + 32'(stall[0]);
         perf_flush_cnt <= perf_flush_cnt + 32'(in_flush);
      end
   end
`else
   assign perf_stall_cyc = 32'h0;
   assign perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus checked against a depth-based behavioural model
module tb_pipe_hazard_ctrl;
   localparam int TO = 8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  stallreq = '0;
   logic        mc_start = 1'b0, mc_done = 1'b0, flush_req = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [5:0]  stall, flush;
   logic        redirect_valid, mc_abort, stall_timeout;
   logic [31:0] redirect_pc, perf_stall_cyc, perf_flush_cnt;
   int checks = 0, failures = 0;
   bit armed = 1'b0;
   // model: op pending, in flush cycle, abort flag, pc, watchdog, perf
   bit          m_mc = 0, m_fl = 0, m_ab = 0, m_to = 0;
   logic [31:0] m_pc = '0, m_ps = '0, m_pf = '0;
   int          m_wd = 0;
   always #5 clk = ~clk;
   pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start), .mc_done(mc_done),
      .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mc_abort(mc_abort),
      .stall_timeout(stall_timeout), .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
   );
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
      end
   endtask
   // Deepest stalled stage: ID source reaches 2, EX source and pending mul/div reach 3.
   function automatic int exp_depth();
      int d;
      d = -1;
      if (!rst || m_fl) return -1;
      if (stallreq[0]) d = 2;
      if (stallreq[1]) d = 3;
      if ((m_mc || mc_start) && !mc_done) d = 3;
      return d;
   endfunction
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mc <= 0; m_fl <= 0; m_ab <= 0; m_to <= 0;
         m_pc <= '0; m_ps <= '0; m_pf <= '0; m_wd <= 0;
      end else begin
         m_wd <= (exp_depth() >= 0) ? ((m_wd < TO) ? m_wd + 1 : m_wd) : 0;
         m_to <= m_to || (exp_depth() >= 0 && m_wd + 1 >= TO);
         m_ps <= m_ps + 32'(exp_depth() >= 0);
         m_pf <= m_pf + 32'(m_fl);
         m_fl <= flush_req;
         m_ab <= flush_req && m_mc;
         m_mc <= !flush_req && !m_fl && (m_mc || mc_start) && !mc_done;
         if (flush_req) m_pc <= flush_pc;
      end
   end
   always @(negedge clk) begin
      int d;
      logic [5:0] es, ef;
      if (armed) begin
         d  = exp_depth();
         es = 6'((1 << (d + 1)) - 1);
         ef = (d >= 0) ? 6'(1 << (d + 1)) : 6'd0;
         if (rst && m_fl) ef = 6'b011110;
         chk("m_stall", 32'(stall), 32'(es));
         chk("m_flush", 32'(flush), 32'(ef));
         chk("m_redir_v", 32'(redirect_valid), 32'(rst && m_fl));
         chk("m_redir_pc", redirect_pc, m_pc);
         chk("m_abort", 32'(mc_abort), 32'(rst && m_fl && m_ab));
         chk("m_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef PIPE_CTRL_PERF_CNT_EN
         chk("m_perf_s", perf_stall_cyc, m_ps);
         chk("m_perf_f", perf_flush_cnt, m_pf);
`else
         chk("m_perf_s", perf_stall_cyc, 32'h0);
         chk("m_perf_f", perf_flush_cnt, 32'h0);
`endif
      end
   end
   task automatic nx();
      @(posedge clk);
      #1;
   endtask
   task automatic outs(input string n, input logic [5:0] es, input logic [5:0] ef, input logic rv, input logic ab);
      chk({n, "_stall"}, 32'(stall), 32'(es));
      chk({n, "_flush"}, 32'(flush), 32'(ef));
      chk({n, "_rv"}, 32'(redirect_valid), 32'(rv));
      chk({n, "_abort"}, 32'(mc_abort), 32'(ab));
   endtask
   initial begin
      #2 rst = 1'b0;
      armed = 1'b1;
      @(negedge clk);
      outs("rst", 6'b0, 6'b0, 0, 0);
      chk("rst_pc", redirect_pc, 32'h0);
      chk("rst_to", 32'(stall_timeout), 32'h0);
      nx(); nx();
      rst = 1'b1;
      nx();
      stallreq = 2'b01;
      repeat (3) begin
         @(negedge clk); outs("req0", 6'b000111, 6'b001000, 0, 0); nx();
      end
      stallreq = 2'b00;
      @(negedge clk); outs("req0_rel", 6'b0, 6'b0, 0, 0); nx();
      flush_req = 1'b1; flush_pc = 32'h8000_0100;
      @(negedge clk); outs("fl_req", 6'b0, 6'b0, 0, 0); nx();
      flush_pc = 32'h8000_0200;
      @(negedge clk); outs("fl1", 6'b0, 6'b011110, 1, 0);
      chk("fl1_pc", redirect_pc, 32'h8000_0100); nx();
      flush_req = 1'b0;
      @(negedge clk); outs("fl2", 6'b0, 6'b011110, 1, 0);
      chk("fl2_pc", redirect_pc, 32'h8000_0200); nx();
      @(negedge clk); outs("fl_done", 6'b0, 6'b0, 0, 0);
`ifdef PIPE_CTRL_PERF_CNT_EN
      chk("perf_s3", perf_stall_cyc, 32'd3);
      chk("perf_f2", perf_flush_cnt, 32'd2);
`else
      chk("perf_s0", perf_stall_cyc, 32'd0);
      chk("perf_f0", perf_flush_cnt, 32'd0);
`endif
      nx();
      mc_start = 1'b1;
      @(negedge clk); outs("mc_start", 6'b001111, 6'b010000, 0, 0); nx();
      mc_start = 1'b0;
      repeat (4) begin
         @(negedge clk); outs("mc_wait", 6'b001111, 6'b010000, 0, 0); nx();
      end
      mc_done = 1'b1;
      @(negedge clk); outs("mc_done", 6'b0, 6'b0, 0, 0); nx();
      mc_done = 1'b0;
      @(negedge clk); outs("mc_idle", 6'b0, 6'b0, 0, 0); nx();
      mc_start = 1'b1; mc_done = 1'b1;
      @(negedge clk); outs("mc_1cyc", 6'b0, 6'b0, 0, 0); nx();
      mc_start = 1'b0; mc_done = 1'b0;
      @(negedge clk); outs("mc_1cyc_after", 6'b0, 6'b0, 0, 0); nx();
      mc_start = 1'b1;
      @(negedge clk); outs("t4_start", 6'b001111, 6'b010000, 0, 0); nx();
      mc_start = 1'b0; flush_req = 1'b1; flush_pc = 32'hBFC0_0380;
      @(negedge clk); outs("t4_req", 6'b001111, 6'b010000, 0, 0); nx();
      flush_req = 1'b0;
      @(negedge clk); outs("t4_fl", 6'b0, 6'b011110, 1, 1);
      chk("t4_pc", redirect_pc, 32'hBFC0_0380); nx();
      @(negedge clk); outs("t4_run", 6'b0, 6'b0, 0, 0); nx();
      mc_start = 1'b1; flush_req = 1'b1; flush_pc = 32'h0000_1234;
      @(negedge clk); outs("fs_req", 6'b001111, 6'b010000, 0, 0); nx();
      mc_start = 1'b0; flush_req = 1'b0;
      @(negedge clk); outs("fs_fl", 6'b0, 6'b011110, 1, 0); nx();
      @(negedge clk); outs("fs_run", 6'b0, 6'b0, 0, 0); nx();
      stallreq = 2'b10;
      for (int j = 1; j <= TO; j++) begin
         @(negedge clk); outs("wd_hold", 6'b001111, 6'b010000, 0, 0);
         chk("wd_pre", 32'(stall_timeout), 32'h0); nx();
      end
      stallreq = 2'b00;
      @(negedge clk); chk("wd_fire", 32'(stall_timeout), 32'h1);
      outs("wd_rel", 6'b0, 6'b0, 0, 0);
      repeat (3) nx();
      @(negedge clk); chk("wd_sticky", 32'(stall_timeout), 32'h1); nx();
      stallreq = 2'b01; mc_start = 1'b1;
      @(negedge clk); outs("ar_pre", 6'b001111, 6'b010000, 0, 0); nx();
      mc_start = 1'b0;
      #2 rst = 1'b0;
      #1;
      outs("ar", 6'b0, 6'b0, 0, 0);
      chk("ar_pc", redirect_pc, 32'h0);
      chk("ar_to", 32'(stall_timeout), 32'h0);
      chk("ar_perf_s", perf_stall_cyc, 32'h0);
      chk("ar_perf_f", perf_flush_cnt, 32'h0);
      stallreq = 2'b00;
      nx();
      rst = 1'b1;
      @(negedge clk); outs("ar_after", 6'b0, 6'b0, 0, 0); nx();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
